// File: rtl/hpdcache_refill_arbiter.sv
// Round-robin arbiter that shares the refill downsizer write port between N_REQ sources,
// locking the grant for a whole BEATS-flit line. Define HPDCACHE_REFILL_ARB_FIXED_PRIO_EN for fixed priority.
module hpdcache_refill_arbiter #(
    parameter  int unsigned N_REQ = 2,
    parameter  int unsigned WIDTH = 128,
    parameter  int unsigned BEATS = 4,
    localparam int unsigned ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [N_REQ-1:0]       req_valid_i,
    output logic [N_REQ-1:0]       req_ready_o,
    input  logic [N_REQ*WIDTH-1:0] req_data_i,
    input  logic [N_REQ-1:0]       req_last_i,
    output logic                   dn_w_o,
    input  logic                   dn_wok_i,
    output logic [WIDTH-1:0]       dn_wdata_o,
    output logic [ID_W-1:0]        dn_src_o,
    output logic                   busy_o,
    output logic                   err_o
);

    localparam int unsigned       BW        = $clog2(BEATS) + 1;
    localparam logic [BW-1:0]     LAST_BEAT = BW'(BEATS - 1);
    localparam logic [ID_W-1:0]   LAST_ID   = ID_W'(N_REQ - 1);
    localparam logic [ID_W:0]     N_REQ_W   = (ID_W + 1)'(N_REQ);

    typedef enum logic {IDLE, BURST} state_e;

    state_e          state_q;
    logic [ID_W-1:0] grant_q;
    logic [ID_W-1:0] rr_q;
    logic [BW-1:0]   beat_q;
    logic            err_q;

    logic [ID_W-1:0]  sel;
    logic [ID_W:0]    idx_w;
    logic [WIDTH-1:0] data_w [N_REQ];
    logic [BW-1:0]    beat_idx;
    logic             xfer;
    logic             exp_last;

    function automatic logic [ID_W-1:0] next_rr(input logic [ID_W-1:0] last_grant);
`ifdef HPDCACHE_REFILL_ARB_FIXED_PRIO_EN
        return last_grant & '0;
`else
        return (last_grant == LAST_ID) ? '0 : last_grant + 1'b1;
`endif
    endfunction

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
            assign data_w[gi]      = req_data_i[gi*WIDTH +: WIDTH];
            assign req_ready_o[gi] = rst_ni && dn_wok_i && (sel == ID_W'(gi));
        end
    endgenerate

    // Scan downwards so the requester closest to rr_q is the last (winning) assignment.
    always_comb begin
        sel   = grant_q;
        idx_w = '0;
        if (state_q == IDLE) begin
            sel = rr_q;
            for (int k = N_REQ - 1; k >= 0; k--) begin
                idx_w = {1'b0, rr_q} + (ID_W + 1)'(k);
                if (idx_w >= N_REQ_W) begin
                    idx_w = idx_w - N_REQ_W;
                end
                if (req_valid_i[idx_w[ID_W-1:0]]) begin
                    sel = idx_w[ID_W-1:0];
                end
            end
        end
    end

    // Push request depends only on valids and state, never on dn_wok_i.
    assign dn_w_o     = rst_ni && ((state_q == BURST) ? req_valid_i[sel] : |req_valid_i);
    assign xfer       = dn_w_o && dn_wok_i;
    assign beat_idx   = (state_q == BURST) ? beat_q : '0;
    assign exp_last   = (beat_idx == LAST_BEAT);
    assign dn_wdata_o = data_w[sel];
    assign dn_src_o   = sel;
    assign busy_o     = (state_q == BURST);
    assign err_o      = err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            grant_q <= '0;
            rr_q    <= '0;
            beat_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= xfer && (req_last_i[sel] != exp_last);
            case (state_q)
                IDLE: begin
                    if (xfer) begin
                        if (BEATS == 1) begin
                            rr_q <= next_rr(sel);
                        end else begin
                            state_q <= BURST;
                            grant_q <= sel;
                            beat_q  <= BW'(1);
                        end
                    end
                end
                BURST: begin
                    if (xfer) begin
                        if (beat_q == LAST_BEAT) begin
                            state_q <= IDLE;
                            beat_q  <= '0;
                            rr_q    <= next_rr(grant_q);
                        end else begin
                            beat_q <= beat_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hpdcache_refill_arbiter.sv
// Scoreboard bench for hpdcache_refill_arbiter (N_REQ=2, WIDTH=128, BEATS=4).
module tb_hpdcache_refill_arbiter;

    localparam int N = 2;
    localparam int W = 128;
    localparam int B = 4;

    logic           clk_i = 1'b0;
    logic           rst_ni = 1'b0;
    logic [N-1:0]   req_valid_i;
    logic [N-1:0]   req_ready_o;
    logic [N*W-1:0] req_data_i;
    logic [N-1:0]   req_last_i;
    logic           dn_w_o;
    logic           dn_wok_i;
    logic [W-1:0]   dn_wdata_o;
    logic [0:0]     dn_src_o;
    logic           busy_o;
    logic           err_o;

    hpdcache_refill_arbiter #(.N_REQ(N), .WIDTH(W), .BEATS(B)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_data_i(req_data_i), .req_last_i(req_last_i),
        .dn_w_o(dn_w_o), .dn_wok_i(dn_wok_i), .dn_wdata_o(dn_wdata_o),
        .dn_src_o(dn_src_o), .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    // Source queues hold {last, data}; scoreboard holds {src, data}.
    logic [W:0] src0_q[$];
    logic [W:0] src1_q[$];
    logic [W:0] exp_q[$];
    logic [N-1:0] en;
    int   n_cmp = 0, n_fail = 0, push_cnt = 0, err_pulses = 0, mdl_beat = 0;
    logic exp_err = 1'b0;

    task automatic drive_inputs();
        req_valid_i[0] = en[0] && (src0_q.size() > 0);
        req_valid_i[1] = en[1] && (src1_q.size() > 0);
        req_data_i[W-1:0]   = (src0_q.size() > 0) ? src0_q[0][W-1:0] : '0;
        req_last_i[0]       = (src0_q.size() > 0) ? src0_q[0][W] : 1'b0;
        req_data_i[2*W-1:W] = (src1_q.size() > 0) ? src1_q[0][W-1:0] : '0;
        req_last_i[1]       = (src1_q.size() > 0) ? src1_q[0][W] : 1'b0;
    endtask

    task automatic add_burst(input logic s, input logic [W-1:0] base, input logic [3:0] lasts);
        for (int k = 0; k < B; k++) begin
            if (s) src1_q.push_back({lasts[k], base + W'(k)});
            else   src0_q.push_back({lasts[k], base + W'(k)});
        end
    endtask

    task automatic expect_burst(input logic s, input logic [W-1:0] base);
        for (int k = 0; k < B; k++) exp_q.push_back({s, base + W'(k)});
    endtask

    task automatic step();
        logic [N-1:0] hs;
        logic [W:0]   e;
        logic         exp_err_n;
        exp_err_n = 1'b0;
        @(negedge clk_i);
        n_cmp++;
        if (err_o !== exp_err) begin
            n_fail++; $display("FAIL err_o: got %b expected %b", err_o, exp_err);
        end
        if (err_o === 1'b1) err_pulses++;
        n_cmp++;
        if (busy_o !== (mdl_beat != 0)) begin
            n_fail++; $display("FAIL busy_o: got %b expected %b", busy_o, (mdl_beat != 0));
        end
        if (dn_wok_i === 1'b0) begin
            n_cmp++;
            if (req_ready_o !== 2'b00) begin
                n_fail++; $display("FAIL ready_bp: got %b expected 00", req_ready_o);
            end
        end
        hs = req_valid_i & req_ready_o;
        if (dn_w_o && dn_wok_i) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++; $display("FAIL push: unexpected src=%0d data=%h", dn_src_o, dn_wdata_o);
            end else begin
                e = exp_q.pop_front();
                if (dn_src_o !== e[W] || dn_wdata_o !== e[W-1:0]) begin
                    n_fail++;
                    $display("FAIL push: got src=%0d data=%h expected src=%0d data=%h",
                             dn_src_o, dn_wdata_o, e[W], e[W-1:0]);
                end else begin
                    $display("push src=%0d data=%h beat=%0d", dn_src_o, dn_wdata_o, mdl_beat);
                end
                n_cmp++;
                if (hs !== (2'b01 << e[W])) begin
                    n_fail++; $display("FAIL handshake: got %b expected %b", hs, (2'b01 << e[W]));
                end
                exp_err_n = (req_last_i[e[W]] != (mdl_beat == B - 1));
            end
            mdl_beat = (mdl_beat + 1) % B;
            push_cnt++;
        end
        @(posedge clk_i);
        #1;
        exp_err = exp_err_n;
        if (hs[0] && src0_q.size() > 0) void'(src0_q.pop_front());
        if (hs[1] && src1_q.size() > 0) void'(src1_q.pop_front());
        drive_inputs();
    endtask

    task automatic run_until(input int target, input int max_cycles);
        for (int i = 0; i < max_cycles && push_cnt < target; i++) step();
        n_cmp++;
        if (push_cnt !== target) begin
            n_fail++; $display("FAIL push_count: got %0d expected %0d (cycle budget)", push_cnt, target);
        end
    endtask

    task automatic clear_model();
        en = 2'b11;
        src0_q.delete(); src1_q.delete(); exp_q.delete();
        mdl_beat = 0; exp_err = 1'b0; push_cnt = 0; err_pulses = 0;
        dn_wok_i = 1'b1;
        drive_inputs();
    endtask

    task automatic apply_reset();
        rst_ni = 1'b0;
        clear_model();
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        req_valid_i = 2'b11; req_data_i = '1; req_last_i = 2'b00; dn_wok_i = 1'b1;
        #3;
        n_cmp++; if (dn_w_o !== 1'b0) begin n_fail++; $display("FAIL rst_dn_w: got %b expected 0", dn_w_o); end
        n_cmp++; if (req_ready_o !== 2'b00) begin n_fail++; $display("FAIL rst_ready: got %b expected 00", req_ready_o); end
        n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy_o); end
        n_cmp++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b expected 0", err_o); end
        apply_reset();
    endtask

    task automatic test_single_burst();
        apply_reset();
        add_burst(1'b0, W'('hA0), 4'b1000);
        expect_burst(1'b0, W'('hA0));
        drive_inputs();
        run_until(4, 20);
        repeat (2) step();
        n_cmp++; if (dut.rr_q !== 1'b1) begin n_fail++; $display("FAIL single_rr: got %0d expected 1", dut.rr_q); end
        n_cmp++; if (err_pulses !== 0) begin n_fail++; $display("FAIL single_err: got %0d pulses expected 0", err_pulses); end
    endtask

    task automatic test_fairness();
        apply_reset();
        add_burst(1'b0, W'('h00), 4'b1000); add_burst(1'b0, W'('h10), 4'b1000);
        add_burst(1'b1, W'('h100), 4'b1000); add_burst(1'b1, W'('h110), 4'b1000);
`ifdef HPDCACHE_REFILL_ARB_FIXED_PRIO_EN
        expect_burst(1'b0, W'('h00)); expect_burst(1'b0, W'('h10));
        expect_burst(1'b1, W'('h100)); expect_burst(1'b1, W'('h110));
`else
        expect_burst(1'b0, W'('h00)); expect_burst(1'b1, W'('h100));
        expect_burst(1'b0, W'('h10)); expect_burst(1'b1, W'('h110));
`endif
        drive_inputs();
        run_until(16, 60);
    endtask

    task automatic test_backpressure();
        apply_reset();
        add_burst(1'b0, W'('hB0), 4'b1000);
        expect_burst(1'b0, W'('hB0));
        drive_inputs();
        run_until(2, 20);
        dn_wok_i = 1'b0;
        repeat (3) begin
            step();
            n_cmp++;
            if (dut.beat_q !== 3'd2) begin n_fail++; $display("FAIL bp_beat: got %0d expected 2", dut.beat_q); end
        end
        dn_wok_i = 1'b1;
        run_until(4, 20);
        repeat (2) step();
        n_cmp++; if (push_cnt !== 4) begin n_fail++; $display("FAIL bp_total: got %0d expected 4", push_cnt); end
    endtask

    task automatic test_bubble_lock();
        apply_reset();
        add_burst(1'b0, W'('hC0), 4'b1000); add_burst(1'b1, W'('hD0), 4'b1000);
        expect_burst(1'b0, W'('hC0)); expect_burst(1'b1, W'('hD0));
        drive_inputs();
        run_until(2, 20);
        en[0] = 1'b0;
        drive_inputs();
        repeat (2) begin
            #1;
            n_cmp++; if (dn_w_o !== 1'b0) begin n_fail++; $display("FAIL bubble_w: got %b expected 0", dn_w_o); end
            n_cmp++; if (req_ready_o[1] !== 1'b0) begin n_fail++; $display("FAIL bubble_rdy1: got %b expected 0", req_ready_o[1]); end
            step();
        end
        en[0] = 1'b1;
        drive_inputs();
        run_until(8, 40);
    endtask

    task automatic test_framing_error();
        apply_reset();
        add_burst(1'b0, W'('hE0), 4'b1010); add_burst(1'b0, W'('hF0), 4'b0000);
        expect_burst(1'b0, W'('hE0)); expect_burst(1'b0, W'('hF0));
        drive_inputs();
        run_until(8, 40);
        repeat (2) step();
        n_cmp++; if (err_pulses !== 2) begin n_fail++; $display("FAIL frame_pulses: got %0d expected 2", err_pulses); end
    endtask

    task automatic test_reset_mid_burst();
        apply_reset();
        add_burst(1'b0, W'('h50), 4'b1000);
        expect_burst(1'b0, W'('h50));
        drive_inputs();
        run_until(2, 20);
        rst_ni = 1'b0;
        #1;
        n_cmp++; if (dn_w_o !== 1'b0) begin n_fail++; $display("FAIL midrst_w: got %b expected 0", dn_w_o); end
        n_cmp++; if (req_ready_o !== 2'b00) begin n_fail++; $display("FAIL midrst_rdy: got %b expected 00", req_ready_o); end
        n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy_o); end
        n_cmp++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL midrst_err: got %b expected 0", err_o); end
        clear_model();
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        add_burst(1'b1, W'('h60), 4'b1000);
        expect_burst(1'b1, W'('h60));
        drive_inputs();
        run_until(4, 20);
    endtask

    initial begin
        en = 2'b11;
        test_reset();
        test_single_burst();
        test_fairness();
        test_backpressure();
        test_bubble_lock();
        test_framing_error();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
